// File: rtl/uart_word_bridge_if.sv
// uart_word_bridge_if: groups the word-side handshakes and the byte-UART FIFO
// strobes of uart_word_bridge. The bridge connects through the slave modport.
// The master modport is the environment around it: the CPU-side logic plus the
// UART FIFOs.
interface uart_word_bridge_if #(
  parameter int WORD_BYTES = 4
);
  localparam int W = 8 * WORD_BYTES;

  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] tx_word;
  logic         rx_valid;
  logic         rx_ready;
  logic [W-1:0] rx_word;
  logic         rx_err;
  logic         uart_send_flag;
  logic [7:0]   uart_send_data;
  logic         uart_sendable;
  logic         uart_recv_flag;
  logic [7:0]   uart_recv_data;
  logic         uart_receivable;

  modport slave (
    input  tx_valid, tx_word, rx_ready,
    input  uart_sendable, uart_recv_data, uart_receivable,
    output tx_ready, rx_valid, rx_word, rx_err,
    output uart_send_flag, uart_send_data, uart_recv_flag
  );

  modport master (
    output tx_valid, tx_word, rx_ready,
    output uart_sendable, uart_recv_data, uart_receivable,
    input  tx_ready, rx_valid, rx_word, rx_err,
    input  uart_send_flag, uart_send_data, uart_recv_flag
  );
endinterface

// File: rtl/uart_word_bridge.sv
// uart_word_bridge: word <-> byte bridge in front of the byte UART FIFOs.
// The TX side splits a word into bytes, least significant byte first, and
// pushes them into the send FIFO. The RX side pops bytes from the receive FIFO
// and reassembles them into a word, which it offers with a valid/ready handshake.
// After every push or pop there is one idle cycle, so that the FIFO status flags
// can settle before the FSM samples them again.
// Optional feature macro: CHECKSUM_EN. When it is defined, an XOR checksum byte
// follows every word. On a checksum mismatch the RX side drops the word and
// pulses rx_err.
module uart_word_bridge #(
  parameter int WORD_BYTES = 4
) (
  input  logic               CLK,
  input  logic               RST,
  uart_word_bridge_if.slave  bus
);
  localparam int W = 8 * WORD_BYTES;
`ifdef CHECKSUM_EN
  localparam int NBYTES = WORD_BYTES + 1;
  localparam logic [3:0] CKS_IDX = 4'(WORD_BYTES);
`else
  localparam int NBYTES = WORD_BYTES;
`endif
  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_SEND = 2'd1, TX_WAIT = 2'd2} tx_state_t;
  typedef enum logic [1:0] {RX_COLLECT = 2'd0, RX_GAP = 2'd1, RX_FULL = 2'd2} rx_state_t;

  // byte idx of a word; idx must be below WORD_BYTES
  function automatic logic [7:0] byte_at(input logic [W-1:0] w, input logic [3:0] idx);
    logic [W-1:0] sh;
    sh = w >> {idx, 3'b000};
    return sh[7:0];
  endfunction

`ifdef CHECKSUM_EN
  // XOR of all data bytes of a word
  function automatic logic [7:0] word_xor(input logic [W-1:0] w);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < WORD_BYTES; i++) begin
      acc = acc ^ w[8*i +: 8];
    end
    return acc;
  endfunction
`endif

  // ---------------- TX side ----------------
  tx_state_t    tx_state_q, tx_state_d;
  logic [W-1:0] tx_word_q, tx_word_d;
  logic [3:0]   tx_idx_q, tx_idx_d;
  logic         tx_ready_q, tx_ready_d;
  logic         send_flag_q, send_flag_d;
  logic [7:0]   send_data_q, send_data_d;
  logic [7:0]   tx_byte_s;

  // select the outgoing byte: a data byte, or the checksum trailer
  always_comb begin
    tx_byte_s = byte_at(tx_word_q, tx_idx_q);
`ifdef CHECKSUM_EN
    if (tx_idx_q == CKS_IDX) begin
      tx_byte_s = word_xor(tx_word_q);
    end else begin
      tx_byte_s = byte_at(tx_word_q, tx_idx_q);
    end
`endif
  end

  // TX next state: accept a word, then push one byte every other cycle while the send FIFO has room
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_word_d   = tx_word_q;
    tx_idx_d    = tx_idx_q;
    tx_ready_d  = tx_ready_q;
    send_flag_d = 1'b0;
    send_data_d = send_data_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_ready_d = 1'b1;
        if (tx_ready_q && bus.tx_valid) begin
          tx_word_d  = bus.tx_word;
          tx_idx_d   = 4'd0;
          tx_ready_d = 1'b0;
          tx_state_d = TX_SEND;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_SEND: begin
        if (bus.uart_sendable) begin
          send_flag_d = 1'b1;
          send_data_d = tx_byte_s;
          tx_state_d  = TX_WAIT;
        end else begin
          tx_state_d  = TX_SEND;
        end
      end
      TX_WAIT: begin
        if (tx_idx_q == LAST_IDX) begin
          tx_idx_d   = 4'd0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_idx_d   = tx_idx_q + 4'd1;
          tx_state_d = TX_SEND;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_idx_d   = 4'd0;
      end
    endcase
  end

  // TX registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state_q  <= TX_IDLE;
      tx_word_q   <= '0;
      tx_idx_q    <= 4'd0;
      tx_ready_q  <= 1'b1;
      send_flag_q <= 1'b0;
      send_data_q <= 8'h00;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_word_q   <= tx_word_d;
      tx_idx_q    <= tx_idx_d;
      tx_ready_q  <= tx_ready_d;
      send_flag_q <= send_flag_d;
      send_data_q <= send_data_d;
    end
  end

  // ---------------- RX side ----------------
  rx_state_t    rx_state_q, rx_state_d;
  logic [3:0]   rx_idx_q, rx_idx_d;
  logic [W-1:0] rx_buf_q, rx_buf_d;
  logic [W-1:0] rx_word_q, rx_word_d;
  logic         rx_valid_q, rx_valid_d;
  logic         recv_flag_q, recv_flag_d;
`ifdef CHECKSUM_EN
  logic [7:0]   rx_cks_q, rx_cks_d;
  logic         rx_err_q, rx_err_d;
`endif

  // RX next state: pop bytes into slots, publish the word, hold it until the consumer takes it
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_idx_d    = rx_idx_q;
    rx_buf_d    = rx_buf_q;
    rx_word_d   = rx_word_q;
    rx_valid_d  = rx_valid_q;
    recv_flag_d = 1'b0;
`ifdef CHECKSUM_EN
    rx_cks_d    = rx_cks_q;
    rx_err_d    = 1'b0;
`endif
    case (rx_state_q)
      RX_COLLECT: begin
        if (bus.uart_receivable) begin
          for (int i = 0; i < WORD_BYTES; i++) begin
            if (rx_idx_q == 4'(i)) begin
              rx_buf_d[8*i +: 8] = bus.uart_recv_data;
            end else begin
              rx_buf_d[8*i +: 8] = rx_buf_q[8*i +: 8];
            end
          end
`ifdef CHECKSUM_EN
          if (rx_idx_q == CKS_IDX) begin
            rx_cks_d = bus.uart_recv_data;
          end else begin
            rx_cks_d = rx_cks_q;
          end
`endif
          recv_flag_d = 1'b1;
          rx_state_d  = RX_GAP;
        end else begin
          rx_state_d  = RX_COLLECT;
        end
      end
      RX_GAP: begin
        if (rx_idx_q == LAST_IDX) begin
          rx_idx_d = 4'd0;
`ifdef CHECKSUM_EN
          if (word_xor(rx_buf_q) == rx_cks_q) begin
            rx_word_d  = rx_buf_q;
            rx_valid_d = 1'b1;
            rx_state_d = RX_FULL;
          end else begin
            rx_err_d   = 1'b1;
            rx_state_d = RX_COLLECT;
          end
`else
          rx_word_d  = rx_buf_q;
          rx_valid_d = 1'b1;
          rx_state_d = RX_FULL;
`endif
        end else begin
          rx_idx_d   = rx_idx_q + 4'd1;
          rx_state_d = RX_COLLECT;
        end
      end
      RX_FULL: begin
        if (bus.rx_ready) begin
          rx_valid_d = 1'b0;
          rx_idx_d   = 4'd0;
          rx_state_d = RX_COLLECT;
        end else begin
          rx_state_d = RX_FULL;
        end
      end
      default: begin
        rx_state_d = RX_COLLECT;
        rx_idx_d   = 4'd0;
        rx_valid_d = 1'b0;
      end
    endcase
  end

  // RX registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state_q  <= RX_COLLECT;
      rx_idx_q    <= 4'd0;
      rx_buf_q    <= '0;
      rx_word_q   <= '0;
      rx_valid_q  <= 1'b0;
      recv_flag_q <= 1'b0;
`ifdef CHECKSUM_EN
      rx_cks_q    <= 8'h00;
      rx_err_q    <= 1'b0;
`endif
    end else begin
      rx_state_q  <= rx_state_d;
      rx_idx_q    <= rx_idx_d;
      rx_buf_q    <= rx_buf_d;
      rx_word_q   <= rx_word_d;
      rx_valid_q  <= rx_valid_d;
      recv_flag_q <= recv_flag_d;
`ifdef CHECKSUM_EN
      rx_cks_q    <= rx_cks_d;
      rx_err_q    <= rx_err_d;
`endif
    end
  end

  assign bus.tx_ready       = tx_ready_q;
  assign bus.uart_send_flag = send_flag_q;
  assign bus.uart_send_data = send_data_q;
  assign bus.rx_valid       = rx_valid_q;
  assign bus.rx_word        = rx_word_q;
  assign bus.uart_recv_flag = recv_flag_q;
`ifdef CHECKSUM_EN
  assign bus.rx_err         = rx_err_q;
`else
  assign bus.rx_err         = 1'b0;
`endif
endmodule

// File: tb/tb_uart_word_bridge.sv
// tb_uart_word_bridge: directed, table-driven bench for uart_word_bridge
// (WORD_BYTES = 4). Models the UART send FIFO (a capture queue) and the UART
// receive FIFO (a byte queue) around the bridge.
module tb_uart_word_bridge;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_word_bridge_if #(.WORD_BYTES(4)) bus ();
  uart_word_bridge #(.WORD_BYTES(4)) dut (.CLK(clk), .RST(rst), .bus(bus));

`ifdef CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  logic [7:0] rx_q[$];
  logic [7:0] sent_q[$];
  int sent_cyc[$];
  logic rx_en = 1'b1;
  int pop_count = 0;
  int err_count = 0;
  int push_full = 0;
  int pop_empty = 0;
  logic snd_at_edge = 1'b0;
  logic rcv_at_edge = 1'b0;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b0, b1, b2, b3, cks;
  } vec_t;
  vec_t vecs[6];

  // cycle count and FIFO flags as seen by the DUT at each active edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    snd_at_edge <= bus.uart_sendable;
    rcv_at_edge <= bus.uart_receivable;
  end

  // FIFO models: capture pushes, apply pops, count error pulses, refresh FIFO status
  always @(negedge clk) begin
    if (bus.uart_send_flag) begin
      if (!snd_at_edge) push_full++;
      sent_q.push_back(bus.uart_send_data);
      sent_cyc.push_back(cyc);
    end
    if (bus.uart_recv_flag) begin
      if (!rcv_at_edge || rx_q.size() == 0) pop_empty++;
      else void'(rx_q.pop_front());
      pop_count++;
    end
    if (bus.rx_err) err_count++;
    bus.uart_receivable = rx_en && (rx_q.size() > 0);
    bus.uart_recv_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, output int t);
    int k;
    k = 0;
    while (!bus.tx_ready && k < 100) begin @(negedge clk); k++; end
    if (!bus.tx_ready) check("tx_ready_timeout", 64'd0, 64'd1);
    t = cyc + 1;
    bus.tx_valid = 1'b1;
    bus.tx_word  = w;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_sent(input int n);
    int k;
    k = 0;
    while (sent_q.size() < n && k < 300) begin @(negedge clk); k++; end
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!bus.rx_valid && k < 400) begin @(negedge clk); k++; end
    check(name, 64'(bus.rx_valid), 64'd1);
  endtask

  task automatic release_rx();
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    check("rx_valid_clear", 64'(bus.rx_valid), 64'd0);
  endtask

  task automatic clear_sent();
    sent_q.delete();
    sent_cyc.delete();
  endtask

  function automatic logic [63:0] sent_at(input int j);
    if (j < sent_q.size()) return 64'(sent_q[j]);
    else return 64'hDEAD;
  endfunction

  initial begin
    int t;
    int k;
    int p0;
    int e0;
    logic [7:0] exp_b[5];
    logic seen_valid;

    vecs[0] = '{32'hA1B2C3D4, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h04};
    vecs[1] = '{32'h12345678, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    vecs[2] = '{32'hDEADBEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    vecs[3] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    vecs[5] = '{32'h80000001, 8'h01, 8'h00, 8'h00, 8'h80, 8'h81};

    bus.tx_valid = 1'b0;
    bus.tx_word = 32'h0;
    bus.rx_ready = 1'b0;
    bus.uart_sendable = 1'b1;
    rst = 1'b1;
    tick(3);
    check("reset_flags", 64'({bus.tx_ready, bus.rx_valid, bus.rx_err, bus.uart_send_flag, bus.uart_recv_flag}), 64'h10);
    check("reset_rx_word", 64'(bus.rx_word), 64'h0);
    check("reset_send_data", 64'(bus.uart_send_data), 64'h0);
    rst = 1'b0;
    tick(2);

    // TX basic timing
    clear_sent();
    send_word(32'hA1B2C3D4, t);
    wait_sent(NB);
    check("t1_push_count", 64'(sent_q.size()), 64'(NB));
    for (int i = 0; i < NB; i++) begin
      check("t1_push_cycle", (i < sent_cyc.size()) ? 64'(sent_cyc[i] - t) : 64'hDEAD, 64'(1 + 2*i));
    end
    k = 0;
    while (!bus.tx_ready && k < 50) begin @(negedge clk); k++; end
    check("t1_tx_ready_cycle", 64'(cyc - t), 64'(1 + 2*NB));

    // table: TX byte order and RX reassembly per vector
    for (int v = 0; v < 6; v++) begin
      exp_b[0] = vecs[v].b0; exp_b[1] = vecs[v].b1; exp_b[2] = vecs[v].b2;
      exp_b[3] = vecs[v].b3; exp_b[4] = vecs[v].cks;
      clear_sent();
      send_word(vecs[v].word, t);
      wait_sent(NB);
      for (int j = 0; j < NB; j++) check("tbl_tx_byte", sent_at(j), 64'(exp_b[j]));
      for (int j = 0; j < NB; j++) rx_q.push_back(exp_b[j]);
      wait_valid("tbl_rx_valid");
      check("tbl_rx_word", 64'(bus.rx_word), 64'(vecs[v].word));
      release_rx();
    end

    // TX stall after the second push
    tick(4);
    clear_sent();
    send_word(32'h0BADF00D, t);
    wait_sent(2);
    bus.uart_sendable = 1'b0;
    tick(10);
    check("t2_no_push_stalled", 64'(sent_q.size()), 64'd2);
    bus.uart_sendable = 1'b1;
    wait_sent(NB);
    check("t2_byte3", sent_at(2), 64'h0AD);
    check("t2_byte4", sent_at(3), 64'h00B);

    // RX hold with the next word already queued
    tick(4);
    p0 = pop_count;
    rx_q.push_back(8'h78); rx_q.push_back(8'h56); rx_q.push_back(8'h34); rx_q.push_back(8'h12);
`ifdef CHECKSUM_EN
    rx_q.push_back(8'h08);
`endif
    rx_q.push_back(8'h01); rx_q.push_back(8'h02); rx_q.push_back(8'h03); rx_q.push_back(8'h04);
`ifdef CHECKSUM_EN
    rx_q.push_back(8'h04);
`endif
    wait_valid("t3_rx_valid");
    check("t3_rx_word", 64'(bus.rx_word), 64'h12345678);
    check("t3_pops", 64'(pop_count - p0), 64'(NB));
    tick(10);
    check("t3_no_pop_held", 64'(pop_count - p0), 64'(NB));
    check("t3_still_valid", 64'(bus.rx_valid), 64'd1);
    check("t3_word_stable", 64'(bus.rx_word), 64'h12345678);
    release_rx();
    wait_valid("t3_next_valid");
    check("t3_next_word", 64'(bus.rx_word), 64'h04030201);
    release_rx();

    // RX bytes arriving 20 cycles apart
    p0 = pop_count;
    exp_b[0] = 8'h78; exp_b[1] = 8'h56; exp_b[2] = 8'h34; exp_b[3] = 8'h12; exp_b[4] = 8'h08;
    for (int j = 0; j < NB; j++) begin
      rx_q.push_back(exp_b[j]);
      tick(20);
    end
    wait_valid("t4_rx_valid");
    check("t4_rx_word", 64'(bus.rx_word), 64'h12345678);
    check("t4_pops", 64'(pop_count - p0), 64'(NB));
    release_rx();

    // reset in the middle of a received word
    p0 = pop_count;
    rx_q.push_back(8'hAA); rx_q.push_back(8'hBB);
    k = 0;
    while (pop_count < p0 + 2 && k < 50) begin @(negedge clk); k++; end
    tick(3);
    rst = 1'b1;
    tick(2);
    check("t5_reset_tx_ready", 64'(bus.tx_ready), 64'd1);
    rst = 1'b0;
    tick(1);
    rx_q.push_back(8'h01); rx_q.push_back(8'h02); rx_q.push_back(8'h03); rx_q.push_back(8'h04);
`ifdef CHECKSUM_EN
    rx_q.push_back(8'h04);
`endif
    wait_valid("t5_rx_valid");
    check("t5_rx_word", 64'(bus.rx_word), 64'h04030201);
    release_rx();

`ifdef CHECKSUM_EN
    // a bad checksum trailer drops the word and pulses rx_err
    e0 = err_count;
    seen_valid = 1'b0;
    rx_q.push_back(8'h78); rx_q.push_back(8'h56); rx_q.push_back(8'h34);
    rx_q.push_back(8'h12); rx_q.push_back(8'h09);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (bus.rx_valid) seen_valid = 1'b1;
    end
    check("t6_err_pulses", 64'(err_count - e0), 64'd1);
    check("t6_no_valid", 64'(seen_valid), 64'd0);
    rx_q.push_back(8'h01); rx_q.push_back(8'h02); rx_q.push_back(8'h03);
    rx_q.push_back(8'h04); rx_q.push_back(8'h04);
    wait_valid("t6_resume_valid");
    check("t6_resume_word", 64'(bus.rx_word), 64'h04030201);
    release_rx();
`else
    e0 = 0;
    check("no_rx_err", 64'(err_count - e0), 64'd0);
`endif

    check("no_push_when_full", 64'(push_full), 64'd0);
    check("no_pop_when_empty", 64'(pop_empty), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
